// File: rtl/harmonic_mixer.sv
// harmonic_mixer: walks N harmonics per frame, weights each sine sample by a decaying level, accumulates and emits a saturated 16-bit mix
module harmonic_mixer #(
  parameter int MAX_HARM  = 256,
  parameter int ACC_W     = 26,
  parameter int OUT_SHIFT = 4,
  parameter int READY_DLY = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Frame_Tick,
  input  logic [7:0]  i_Harm_Count,
  input  logic [15:0] i_Decay,
  input  logic        i_Sample_Ready,
  input  logic [15:0] i_Sample_Value,
  input  logic        i_Freq_Too_High,
  output logic [7:0]  o_Harmonic,
  output logic        o_Next_Sample,
  output logic [15:0] o_Mix,
  output logic        o_Mix_Valid,
  output logic        o_Overrun
);
  localparam int CW = $clog2(MAX_HARM) + 1;
  localparam int DW = $clog2(READY_DLY + 2);
  localparam logic signed [ACC_W-1:0] MAXV = 32767;
  localparam logic signed [ACC_W-1:0] MINV = -32768;
  typedef enum logic [2:0] {IDLE, WAIT_RDY, SETTLE, CAPTURE, WAIT_LOW, DONE} state_t;
  state_t state, state_n;
  logic [1:0] rst_sync;
  logic rst_n;
  logic [CW-1:0] count;
  logic [DW-1:0] dly;
  logic [15:0] level;
  logic done, last;
  logic signed [ACC_W-1:0] acc, acc_sh, wt;
  logic signed [32:0] prod;
  logic [31:0] lvl_prod;
  logic [15:0] sat;
  assign rst_n = rst_sync[1];
  assign prod = $signed(i_Sample_Value) * $signed({1'b0, level});
  assign wt = ACC_W'(prod >>> 16);
  assign lvl_prod = level * i_Decay;
  assign acc_sh = acc >>> OUT_SHIFT;
  assign sat = acc_sh > MAXV ? 16'h7FFF : acc_sh < MINV ? 16'h8000 : acc_sh[15:0];
  assign last = (CW'(o_Harmonic) == count - CW'(1)) || i_Freq_Too_High;
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = i_Frame_Tick ? WAIT_RDY : IDLE;
      WAIT_RDY: state_n = i_Sample_Ready ? SETTLE : WAIT_RDY;
      SETTLE:   state_n = dly == '0 ? CAPTURE : SETTLE;
      CAPTURE:  state_n = WAIT_LOW;
      WAIT_LOW: state_n = i_Sample_Ready ? WAIT_LOW : done ? DONE : WAIT_RDY;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      o_Harmonic <= '0;
      o_Next_Sample <= 1'b0;
      o_Mix <= '0;
      o_Mix_Valid <= 1'b0;
      o_Overrun <= 1'b0;
      level <= 16'hFFFF;
      acc <= '0;
      count <= '0;
      dly <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      o_Next_Sample <= 1'b0;
      o_Mix_Valid <= 1'b0;
      if (i_Frame_Tick && state != IDLE) o_Overrun <= 1'b1;
      case (state)
        IDLE: if (i_Frame_Tick) begin
          acc <= '0;
          level <= 16'hFFFF;
          count <= (i_Harm_Count == 8'd0) ? CW'(MAX_HARM) : CW'(i_Harm_Count);
          done <= 1'b0;
          o_Harmonic <= '0;
        end
        WAIT_RDY: dly <= DW'(READY_DLY);
        SETTLE: if (dly != '0) dly <= dly - DW'(1);
        CAPTURE: begin
          acc <= acc + wt;
          level <= 16'(lvl_prod >> 16);
          o_Next_Sample <= 1'b1;
          o_Harmonic <= last ? 8'd0 : o_Harmonic + 8'd1;
          done <= last;
        end
        DONE: begin
          o_Mix <= sat;
          o_Mix_Valid <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_harmonic_mixer.sv
// tb_harmonic_mixer: scoreboard bench with a handshaking producer model for harmonic_mixer
module tb_harmonic_mixer;
  logic clk = 0, rst_n = 0, tick = 0, rdy = 0, fth = 0;
  logic [7:0] hcnt = 0;
  logic [15:0] decay = 0, val = 0;
  logic [7:0] harm;
  logic nxt, mix_v, ovr;
  logic [15:0] mix;
  logic [15:0] samp [256];
  logic [15:0] exp_q [$];
  logic [7:0] hseq [$];
  int n_checks = 0, n_fail = 0, nvalid = 0, npulse = 0, exp_caps = 0, v0 = 0;
  int fth_at = -1, hold = 0, rel = -1, gap = 0;
  string tag = "init";

  harmonic_mixer dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Frame_Tick(tick), .i_Harm_Count(hcnt),
    .i_Decay(decay), .i_Sample_Ready(rdy), .i_Sample_Value(val), .i_Freq_Too_High(fth),
    .o_Harmonic(harm), .o_Next_Sample(nxt), .o_Mix(mix), .o_Mix_Valid(mix_v), .o_Overrun(ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string t, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", t, act, exp);
    end
  endtask

  function automatic logic [15:0] model(int n, int dec, int ft);
    longint acc = 0, lvl = 65535, s;
    for (int h = 0; h < n; h++) begin
      s = longint'($signed(samp[h]));
      acc = acc + ((s * lvl) >>> 16);
      lvl = (lvl * dec) >>> 16;
      if (h == ft) break;
    end
    acc = acc >>> 4;
    return acc > 32767 ? 16'h7FFF : acc < -32768 ? 16'h8000 : 16'(acc);
  endfunction

  initial forever begin
    @(negedge clk);
    if (rdy && nxt) begin
      npulse++;
      hseq.push_back(harm);
      rel = hold;
    end
    if (rel > 0) rel--;
    else if (rel == 0) begin
      rdy = 0;
      fth = 0;
      gap = 2;
      rel = -1;
    end else if (!rdy && gap > 0) gap--;
    else begin
      val = samp[harm];
      fth = (int'(harm) == fth_at);
      rdy = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mix_v) begin
      nvalid++;
      check({tag, "_pending"}, 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check(tag, 32'(mix), 32'(exp_q.pop_front()));
    end
  end

  task automatic start_frame(input int n8, input int dec, input int ft, input int hd, input string t);
    int n;
    n = (n8 == 0) ? 256 : n8;
    hcnt = 8'(n8);
    decay = 16'(dec);
    fth_at = ft;
    hold = hd;
    tag = t;
    exp_q.push_back(model(n, dec, ft));
    exp_caps = (ft >= 0 && ft < n) ? ft + 1 : n;
    npulse = 0;
    hseq.delete();
    v0 = nvalid;
    @(negedge clk);
    tick = 1;
    @(negedge clk);
    tick = 0;
  endtask

  task automatic finish_frame();
    int k;
    k = 0;
    while (nvalid == v0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 32'(nvalid > v0), 1);
    if (nvalid == v0) exp_q.delete();
    repeat (30) @(negedge clk);
    check({tag, "_valid_once"}, nvalid - v0, 1);
    check({tag, "_captures"}, npulse, exp_caps);
    check({tag, "_harm0"}, 32'(harm), 0);
  endtask

  task automatic wait_harm(input int h, input string t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(int'(harm) == h && rdy) && k < 5000);
    check({t, "_reach_harm"}, 32'(int'(harm) == h && rdy), 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) samp[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_harm", 32'(harm), 0);
    check("rst_next", 32'(nxt), 0);
    check("rst_mix", 32'(mix), 0);
    check("rst_valid", 32'(mix_v), 0);
    check("rst_ovr", 32'(ovr), 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    samp[0] = 16'h4000;
    start_frame(1, 16'hFFFF, -1, 0, "t1");
    finish_frame();
    check("t1_const", 32'(mix), 32'h03FF);
    for (int i = 0; i < 4; i++) samp[i] = 16'h7FFF;
    start_frame(4, 16'h8000, -1, 0, "t2");
    finish_frame();
    check("t2_const", 32'(mix), 32'h0EFF);
    check("t2_seq_len", hseq.size(), 4);
    for (int i = 0; i < 4 && i < hseq.size(); i++) check("t2_seq", 32'(hseq[i]), (i + 1) % 4);
    for (int i = 0; i < 256; i++) samp[i] = 16'h7FFF;
    start_frame(0, 16'hFFFF, -1, 0, "t3_pos");
    finish_frame();
    check("t3_pos_sat", 32'(mix), 32'h7FFF);
    for (int i = 0; i < 256; i++) samp[i] = 16'h8000;
    start_frame(0, 16'hFFFF, -1, 0, "t3_neg");
    finish_frame();
    check("t3_neg_sat", 32'(mix), 32'h8000);
    for (int i = 0; i < 10; i++) samp[i] = 16'(i * 1000 - 3000);
    start_frame(10, 16'hE000, 3, 0, "t4");
    finish_frame();
    check("t4_last_harm", 32'(hseq.size() > 0 ? hseq[hseq.size() - 1] : 8'hFF), 0);
    check("t4_no_ovr", 32'(ovr), 0);
    for (int i = 0; i < 4; i++) samp[i] = 16'h1234;
    start_frame(4, 16'hC000, -1, 0, "t5");
    wait_harm(2, "t5");
    @(negedge clk);
    tick = 1;
    @(negedge clk);
    tick = 0;
    finish_frame();
    check("t5_ovr", 32'(ovr), 1);
    v0 = nvalid;
    repeat (100) @(negedge clk);
    check("t5_no_extra", nvalid - v0, 0);
    check("t5_ovr_sticky", 32'(ovr), 1);
    for (int i = 0; i < 6; i++) samp[i] = 16'h2000;
    start_frame(6, 16'hF000, -1, 0, "t6a");
    wait_harm(2, "t6a");
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    check("t6_rst_harm", 32'(harm), 0);
    check("t6_rst_next", 32'(nxt), 0);
    check("t6_rst_mix", 32'(mix), 0);
    check("t6_rst_valid", 32'(mix_v), 0);
    check("t6_rst_ovr", 32'(ovr), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) samp[i] = 16'($urandom);
    start_frame(6, int'($urandom_range(65535)), -1, 3, "t6b");
    finish_frame();
    check("t6_ovr_clear", 32'(ovr), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
